// File: rtl/alu_exec_unit.sv
// Registered MIPS execute unit: decodes an instruction, computes the ALU result,
// resolves branches/jumps, and runs an iterative shift-add multiplier.
// Valid/ready handshake on both the input and output sides.
module alu_exec_unit #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              InValid,
  output logic              InReady,
  input  logic [31:0]       Instruction,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] ALUResult,
  output logic              Zero,
  output logic              PCSrc,
  output logic              Illegal,
  output logic              Busy
);

  localparam int unsigned CntW = $clog2(DATA_W + 1);

  // Opcodes
  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpSlti  = 6'b001010;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpXori  = 6'b001110;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpSp2   = 6'b011100;

  // R-type functs
  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnXor = 6'b100110;
  localparam logic [5:0] FnNor = 6'b100111;
  localparam logic [5:0] FnSlt = 6'b101010;
  localparam logic [5:0] FnSll = 6'b000000;
  localparam logic [5:0] FnSrl = 6'b000010;
  localparam logic [5:0] FnMul = 6'b000010;

  typedef enum logic [1:0] {StIdle, StMul, StWait} state_e;

  state_e            state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              zero_q, zero_d;
  logic              pcsrc_q, pcsrc_d;
  logic              illegal_q, illegal_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic [5:0]        opcode, funct;
  logic [4:0]        shamt;
  logic [15:0]       imm;
  logic [25:0]       target;
  logic [DATA_W-1:0] sext, zext, sum_ab, diff_ab, sum_imm;
  logic              shift_big;
  logic [DATA_W-1:0] dec_res;
  logic              dec_pcsrc, dec_illegal, dec_mul;

  assign opcode = Instruction[31:26];
  assign shamt  = Instruction[10:6];
  assign funct  = Instruction[5:0];
  assign imm    = Instruction[15:0];
  assign target = Instruction[25:0];

  assign sext      = DATA_W'($signed(imm));
  assign zext      = DATA_W'(imm);
  assign sum_ab    = A + B;
  assign diff_ab   = A - B;
  assign sum_imm   = A + sext;
  assign shift_big = (32'(shamt) >= DATA_W);

  // Single-cycle datapath: decode and compute result, branch outcome and legality
  always_comb begin
    dec_res     = '0;
    dec_pcsrc   = 1'b0;
    dec_illegal = 1'b0;
    dec_mul     = 1'b0;
    case (opcode)
      OpRType: begin
        case (funct)
          FnAdd:   dec_res = sum_ab;
          FnSub:   dec_res = diff_ab;
          FnAnd:   dec_res = A & B;
          FnOr:    dec_res = A | B;
          FnXor:   dec_res = A ^ B;
          FnNor:   dec_res = ~(A | B);
          FnSlt:   dec_res[0] = ($signed(A) < $signed(B));
          FnSll:   dec_res = shift_big ? '0 : (B << shamt);
          FnSrl:   dec_res = shift_big ? '0 : (B >> shamt);
          default: dec_illegal = 1'b1;
        endcase
      end
      OpAddi:       dec_res = sum_imm;
      OpSlti:       dec_res[0] = ($signed(A) < $signed(sext));
      OpAndi:       dec_res = A & zext;
      OpOri:        dec_res = A | zext;
      OpXori:       dec_res = A ^ zext;
      OpLw, OpSw:   dec_res = sum_imm;
      OpBeq: begin
        dec_res   = diff_ab;
        dec_pcsrc = (diff_ab == '0);
      end
      OpBne: begin
        dec_res   = diff_ab;
        dec_pcsrc = (diff_ab != '0);
      end
      OpJ: begin
        dec_res   = DATA_W'(target);
        dec_pcsrc = 1'b1;
      end
      OpSp2: begin
        if (funct == FnMul) dec_mul = 1'b1;
        else                dec_illegal = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  assign InReady = (state_q == StIdle) && (!out_valid_q || OutReady);
  assign Busy    = (state_q != StIdle);

  // Next-state: handshake, result register loads and multiplier iteration
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    pcsrc_d     = pcsrc_q;
    illegal_d   = illegal_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;

    // A take clears valid; a load below on the same edge re-sets it.
    if (out_valid_q && OutReady) out_valid_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (InValid && InReady) begin
          if (dec_mul) begin
            mcand_d  = A;
            mplier_d = B;
            acc_d    = '0;
            cnt_d    = CntW'(DATA_W);
            state_d  = StMul;
          end else begin
            result_d    = dec_res;
            zero_d      = (dec_res == '0);
            pcsrc_d     = dec_pcsrc;
            illegal_d   = dec_illegal;
            out_valid_d = 1'b1;
          end
        end
      end
      StMul: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) state_d = StWait;
      end
      StWait: begin
        if (!out_valid_q || OutReady) begin
          result_d    = acc_q;
          zero_d      = (acc_q == '0);
          pcsrc_d     = 1'b0;
          illegal_d   = 1'b0;
          out_valid_d = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and result registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      pcsrc_q     <= 1'b0;
      illegal_q   <= 1'b0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      pcsrc_q     <= pcsrc_d;
      illegal_q   <= illegal_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end

  assign OutValid  = out_valid_q;
  assign ALUResult = result_q;
  assign Zero      = zero_q;
  assign PCSrc     = pcsrc_q;
  assign Illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: a 32-bit and a 16-bit instance share clock and reset.
module tb_alu_exec_unit;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;
  logic Rst;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic        a_zero, a_pcsrc, a_illegal, a_busy;
  logic [31:0] a_instr, a_a, a_b, a_res;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic        b_zero, b_pcsrc, b_illegal, b_busy;
  logic [31:0] b_instr;
  logic [15:0] b_a, b_b, b_res;

  int n_tests = 0;
  int n_fail  = 0;

  alu_exec_unit #(.DATA_W(32)) u_dut32 (
    .Clk(Clk), .Rst(Rst), .InValid(a_in_valid), .InReady(a_in_ready),
    .Instruction(a_instr), .A(a_a), .B(a_b), .OutValid(a_out_valid),
    .OutReady(a_out_ready), .ALUResult(a_res), .Zero(a_zero), .PCSrc(a_pcsrc),
    .Illegal(a_illegal), .Busy(a_busy)
  );

  alu_exec_unit #(.DATA_W(16)) u_dut16 (
    .Clk(Clk), .Rst(Rst), .InValid(b_in_valid), .InReady(b_in_ready),
    .Instruction(b_instr), .A(b_a), .B(b_b), .OutValid(b_out_valid),
    .OutReady(b_out_ready), .ALUResult(b_res), .Zero(b_zero), .PCSrc(b_pcsrc),
    .Illegal(b_illegal), .Busy(b_busy)
  );

  function automatic logic [31:0] rtype(input logic [5:0] f, input logic [4:0] sh);
    return {6'd0, 15'd0, sh, f};
  endfunction
  function automatic logic [31:0] itype(input logic [5:0] op, input logic [15:0] imm);
    return {op, 10'd0, imm};
  endfunction
  function automatic logic [31:0] jtype(input logic [25:0] t);
    return {6'b000010, t};
  endfunction
  localparam logic [31:0] MulInstr = {6'b011100, 20'd0, 6'b000010};

  // Advance one rising edge and settle past it
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Present one instruction to the 32-bit unit and let it be accepted
  task automatic issue32(input logic [31:0] ins, input logic [31:0] av, input logic [31:0] bv);
    a_instr = ins; a_a = av; a_b = bv; a_in_valid = 1'b1;
    step();
    a_in_valid = 1'b0;
  endtask

  task automatic issue16(input logic [31:0] ins, input logic [15:0] av, input logic [15:0] bv);
    b_instr = ins; b_a = av; b_b = bv; b_in_valid = 1'b1;
    step();
    b_in_valid = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    a_in_valid = 0; a_out_ready = 1; a_instr = 0; a_a = 0; a_b = 0;
    b_in_valid = 0; b_out_ready = 1; b_instr = 0; b_a = 0; b_b = 0;
    step(); step();
    n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_outvalid got %b want 0", a_out_valid); end
    n_tests++; if (a_res !== 32'd0) begin n_fail++; $display("FAIL reset_result got %h want 0", a_res); end
    n_tests++; if ({a_zero, a_pcsrc, a_illegal, a_busy} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags got %b want 0000", {a_zero, a_pcsrc, a_illegal, a_busy}); end
    Rst = 1'b0;
    step();
    n_tests++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_inready got %b want 1", a_in_ready); end
  endtask

  task automatic test_back_to_back();
    a_out_ready = 1'b1;
    a_in_valid = 1'b1;
    a_instr = rtype(6'b100000, 5'd0); a_a = 5; a_b = 10;
    step();
    n_tests++; if ({a_out_valid, a_res, a_zero, a_pcsrc} !== {1'b1, 32'd15, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL add v=%b r=%0d z=%b p=%b want 1 15 0 0", a_out_valid, a_res, a_zero, a_pcsrc); end
    a_instr = rtype(6'b100010, 5'd0); a_a = 10; a_b = 5;
    step();
    n_tests++; if ({a_out_valid, a_res} !== {1'b1, 32'd5}) begin
      n_fail++; $display("FAIL sub v=%b r=%0d want 1 5", a_out_valid, a_res); end
    a_instr = rtype(6'b100100, 5'd0); a_a = 12; a_b = 10;
    step();
    n_tests++; if ({a_out_valid, a_res} !== {1'b1, 32'd8}) begin
      n_fail++; $display("FAIL and v=%b r=%0d want 1 8", a_out_valid, a_res); end
    a_in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    int bad;
    a_out_ready = 1'b1;
    issue32(rtype(6'b100101, 5'd0), 32'd12, 32'd3);
    n_tests++; if ({a_out_valid, a_res} !== {1'b1, 32'd15}) begin
      n_fail++; $display("FAIL or v=%b r=%0d want 1 15", a_out_valid, a_res); end
    // Stall with a competing instruction on the input that must be ignored
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_instr = rtype(6'b100000, 5'd0); a_a = 1; a_b = 1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (a_in_ready !== 1'b0) bad++;
      step();
      if (a_out_valid !== 1'b1 || a_res !== 32'd15) bad++;
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL bp_hold errors got %0d want 0", bad); end
    a_out_ready = 1'b1;
    a_instr = itype(6'b001110, 16'd10); a_a = 15; a_b = 0;
    #1;
    n_tests++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b want 1", a_in_ready); end
    step();
    a_in_valid = 1'b0;
    n_tests++; if ({a_out_valid, a_res} !== {1'b1, 32'd5}) begin
      n_fail++; $display("FAIL xori v=%b r=%0d want 1 5", a_out_valid, a_res); end
  endtask

  task automatic test_branch();
    a_out_ready = 1'b1;
    issue32(itype(6'b000100, 16'd0), 32'd5, 32'd5);
    n_tests++; if ({a_res, a_zero, a_pcsrc} !== {32'd0, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL beq r=%h z=%b p=%b want 0 1 1", a_res, a_zero, a_pcsrc); end
    issue32(itype(6'b000101, 16'd0), 32'd5, 32'd5);
    n_tests++; if (a_pcsrc !== 1'b0) begin n_fail++; $display("FAIL bne_eq p=%b want 0", a_pcsrc); end
    issue32(itype(6'b000101, 16'd0), 32'd5, 32'd6);
    n_tests++; if ({a_res, a_zero, a_pcsrc} !== {32'hFFFF_FFFF, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL bne_ne r=%h z=%b p=%b want ffffffff 0 1", a_res, a_zero, a_pcsrc); end
    issue32(jtype(26'd2), 32'd0, 32'd0);
    n_tests++; if ({a_res, a_pcsrc} !== {32'd2, 1'b1}) begin
      n_fail++; $display("FAIL j r=%h p=%b want 2 1", a_res, a_pcsrc); end
  endtask

  task automatic test_misc_ops();
    a_out_ready = 1'b1;
    issue32(itype(6'b100011, 16'hFFFC), 32'd100, 32'd0);
    n_tests++; if ({a_res, a_pcsrc} !== {32'd96, 1'b0}) begin
      n_fail++; $display("FAIL lw r=%0d p=%b want 96 0", a_res, a_pcsrc); end
    issue32(itype(6'b001010, 16'd0), 32'hFFFF_FFFF, 32'd0);
    n_tests++; if (a_res !== 32'd1) begin n_fail++; $display("FAIL slti r=%0d want 1", a_res); end
    issue32(rtype(6'b000010, 5'd4), 32'd0, 32'h8000_0000);
    n_tests++; if (a_res !== 32'h0800_0000) begin n_fail++; $display("FAIL srl r=%h want 08000000", a_res); end
    issue32(rtype(6'b100111, 5'd0), 32'd0, 32'd0);
    n_tests++; if (a_res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL nor r=%h want ffffffff", a_res); end
  endtask

  task automatic test_mul();
    int bad;
    a_out_ready = 1'b1;
    issue32(MulInstr, 32'd7, 32'd6);
    n_tests++; if ({a_busy, a_in_ready} !== 2'b10) begin
      n_fail++; $display("FAIL mul_start busy=%b rdy=%b want 1 0", a_busy, a_in_ready); end
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      if (a_busy !== 1'b1 || a_in_ready !== 1'b0 || a_out_valid !== 1'b0) bad++;
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL mul_run errors got %0d want 0", bad); end
    step();
    n_tests++; if ({a_out_valid, a_res, a_busy, a_zero, a_pcsrc} !== {1'b1, 32'd42, 1'b0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL mul_7x6 v=%b r=%0d busy=%b z=%b p=%b want 1 42 0 0 0",
                         a_out_valid, a_res, a_busy, a_zero, a_pcsrc); end
    issue32(MulInstr, 32'hFFFF_FFFF, 32'd2);
    for (int i = 0; i < 40 && a_out_valid !== 1'b1; i++) step();
    n_tests++; if ({a_out_valid, a_res} !== {1'b1, 32'hFFFF_FFFE}) begin
      n_fail++; $display("FAIL mul_neg v=%b r=%h want 1 fffffffe", a_out_valid, a_res); end
  endtask

  task automatic test_reset_mid_mul();
    int bad;
    a_out_ready = 1'b1;
    issue32(MulInstr, 32'd3, 32'd3);
    repeat (10) step();
    Rst = 1'b1;
    step();
    n_tests++; if ({a_out_valid, a_res, a_zero, a_pcsrc, a_illegal, a_busy} !== 37'd0) begin
      n_fail++; $display("FAIL rst_mul v=%b r=%h z=%b p=%b i=%b busy=%b want all 0",
                         a_out_valid, a_res, a_zero, a_pcsrc, a_illegal, a_busy); end
    Rst = 1'b0;
    step();
    n_tests++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mul_ready got %b want 1", a_in_ready); end
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (a_out_valid !== 1'b0) bad++;
      step();
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL rst_mul_nobeat beats got %0d want 0", bad); end
  endtask

  task automatic test_width16();
    b_out_ready = 1'b1;
    issue16(rtype(6'b100000, 5'd0), 16'hFFFF, 16'd1);
    n_tests++; if ({b_out_valid, b_res, b_zero} !== {1'b1, 16'd0, 1'b1}) begin
      n_fail++; $display("FAIL w16_add v=%b r=%h z=%b want 1 0 1", b_out_valid, b_res, b_zero); end
    issue16(rtype(6'b000000, 5'd20), 16'd0, 16'd1);
    n_tests++; if ({b_res, b_zero} !== {16'd0, 1'b1}) begin
      n_fail++; $display("FAIL w16_sll20 r=%h z=%b want 0 1", b_res, b_zero); end
    issue16(rtype(6'b000000, 5'd4), 16'd0, 16'd1);
    n_tests++; if (b_res !== 16'd16) begin n_fail++; $display("FAIL w16_sll4 r=%h want 0010", b_res); end
    issue16({6'b111111, 26'd0}, 16'd3, 16'd4);
    n_tests++; if ({b_out_valid, b_illegal, b_res, b_zero, b_pcsrc} !== {1'b1, 1'b1, 16'd0, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL w16_illegal v=%b i=%b r=%h z=%b p=%b want 1 1 0 1 0",
                         b_out_valid, b_illegal, b_res, b_zero, b_pcsrc); end
    issue16(itype(6'b001000, 16'hFFFF), 16'd1, 16'd0);
    n_tests++; if ({b_illegal, b_res, b_zero} !== {1'b0, 16'd0, 1'b1}) begin
      n_fail++; $display("FAIL w16_addi i=%b r=%h z=%b want 0 0 1", b_illegal, b_res, b_zero); end
    issue16(MulInstr, 16'h1234, 16'h0010);
    for (int i = 0; i < 25 && b_out_valid !== 1'b1; i++) step();
    n_tests++; if ({b_out_valid, b_res} !== {1'b1, 16'h2340}) begin
      n_fail++; $display("FAIL w16_mul v=%b r=%h want 1 2340", b_out_valid, b_res); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_branch();
    test_misc_ops();
    test_mul();
    test_reset_mid_mul();
    test_width16();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Parametrised, registered execute unit that succeeds the single-cycle controller/ALU/branch test top. It decodes a 32-bit MIPS instruction, computes the ALU result on DATA_W-bit operands, and resolves branches and jumps. Input and output use a valid/ready handshake. A multi-cycle iterative multiplier stalls the input while it runs. It sits between operand fetch and memory/writeback.

## Interface
- DATA_W, 32: operand and result width; legal range 8..64.
- Clk  in  1  rising-edge clock.
- Rst  in  1  synchronous active-high reset.
- InValid  in  1  Instruction/A/B are valid this cycle.
- InReady  out  1  unit accepts input this cycle.
- Instruction  in  32  MIPS encoding: opcode[31:26], shamt[10:6], funct[5:0], imm[15:0], target[25:0].
- A  in  DATA_W  rs operand.
- B  in  DATA_W  rt operand.
- OutValid  out  1  result registers hold a valid result.
- OutReady  in  1  consumer takes the result this cycle.
- ALUResult  out  DATA_W  registered result.
- Zero  out  1  registered (ALUResult == 0).
- PCSrc  out  1  registered branch/jump taken.
- Illegal  out  1  registered; the opcode/funct pair is unsupported.
- Busy  out  1  a multiply is in flight or its result is pending.

## Operation
- A transfer happens when InValid & InReady at a rising edge. A result is taken when OutValid & OutReady at a rising edge.
- InReady = (state==IDLE) & (!OutValid | OutReady).
- Immediate handling:
  - SE = sign-extended imm to DATA_W; ZE = zero-extended imm.
  - Shifts use shamt; if shamt >= DATA_W the result is 0.
- R-type ops (opcode 000000):
  - funct 100000 add A+B; 100010 sub A-B; 100100 and; 100101 or; 100110 xor; 100111 nor.
  - funct 101010 slt: signed compare, result 1/0.
  - funct 000000 sll B<<shamt; 000010 srl B>>shamt, logical.
- I-type ops:
  - 001000 addi A+SE; 001010 slti: signed A<SE, result 1/0.
  - 001100 andi A&ZE; 001101 ori A|ZE; 001110 xori A^ZE.
  - 100011 lw and 101011 sw: A+SE (address).
- Branches: 000100 beq and 000101 bne compute A-B. PCSrc = beq & Zero, or bne & !Zero.
- Jump: 000010 j sets ALUResult = target zero-extended (or truncated) to DATA_W; PCSrc=1.
- Multiply: opcode 011100, funct 000010 (mul) returns the low DATA_W bits of A*B, which are identical for signed and unsigned inputs.
  - Implemented as iterative shift-add, one multiplier bit per cycle, DATA_W iterations.
- Arithmetic wraps modulo 2^DATA_W; no overflow trap.
- Zero is computed over all DATA_W bits for every op. PCSrc=0 for all non-branch, non-jump ops.
- Any other opcode/funct gives ALUResult=0, Zero=1, PCSrc=0, Illegal=1. It still produces a normal result beat.
- State machine:
  - IDLE: a single-cycle op loads the result registers directly. Accepting mul captures A, B, clears the accumulator, loads count=DATA_W, and goes to MUL.
  - MUL: each cycle, if multiplier LSB then acc += multiplicand; multiplicand <<= 1; multiplier >>= 1; count--. After the last iteration, go to WAIT.
  - WAIT: if !OutValid | OutReady, load the result registers, set OutValid, and go to IDLE. Otherwise hold.
- OutValid clears on take unless a new result loads on the same edge. Take and load on the same edge is legal and gives back-to-back throughput of 1/cycle for single-cycle ops.
- Busy = (state != IDLE).

## Timing
- Reset (synchronous, priority over everything):
  - OutValid=0, ALUResult=0, Zero=0, PCSrc=0, Illegal=0, Busy=0, state=IDLE.
  - An in-flight multiply is discarded with no result beat.
  - InReady=1 the cycle after Rst deasserts.
- Single-cycle op accepted at edge N: OutValid=1 and result visible after edge N.
- mul accepted at edge N: Busy=1 and InReady=0 after edge N.
  - Result valid after edge N+DATA_W+1 if the output register is free.
  - Otherwise it waits in WAIT until the pending result is taken.
- Outputs are stable while OutValid & !OutReady.
- Input signals are ignored when InReady=0.

## Test plan
- Reset, then add: A=5, B=10, funct 100000, OutReady=1 -> one cycle later ALUResult=15, Zero=0, PCSrc=0, OutValid=1. Follow with sub 10-5 -> 5 and and 12&10 -> 8 back-to-back, each one cycle apart.
- Back-pressure: hold OutReady=0 after or 12|3 -> ALUResult stays 15 and InReady=0 until OutReady=1; the next xori A=15 imm=10 -> 5.
- Branches: beq A=B=5 -> Zero=1, PCSrc=1. bne A=5, B=5 -> PCSrc=0. bne A=5, B=6 -> PCSrc=1, ALUResult=0xFFFFFFFF. j target 2 -> ALUResult=2, PCSrc=1.
- Multiply: mul A=7, B=6 (DATA_W=32) -> Busy=1, InReady=0 for the full run; ALUResult=42 OutValid after edge N+33. mul A=0xFFFFFFFF, B=2 -> 0xFFFFFFFE.
- Reset mid-mul: assert Rst 10 cycles into a mul -> no result beat; all outputs 0; InReady=1 after Rst deasserts.
- DATA_W=16: add 0xFFFF+1 -> ALUResult=0, Zero=1. sll shamt=20 -> 0. Unsupported opcode 111111 -> Illegal=1, ALUResult=0, Zero=1.
